simple_net: RTL and testbench
=============================

Name:
simple_net

Overview:
- Fixed-topology 2-2-1 binary perceptron network.
- Two hidden threshold neurons feed one output threshold neuron.
- All nine 4-bit signed weights/biases are live input ports, so the network is reconfigurable every cycle.
- Used as a tiny programmable logic-function classifier; with the canonical weight set it computes XOR of x[1:0].
- Pipelined in two registered stages. y is the binary output; tVal exposes the output neuron's pre-activation value for debug.

Parameters:
- WW, 4: weight/bias width, two's complement signed.
- AW, 6: internal accumulator width, signed. It must hold the range -23..+22 for WW=4.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- x, input, 2: binary inputs; x[0] is input A, x[1] is input B.
- w0, input, WW signed: weight from A to hidden neuron H1.
- w1, input, WW signed: weight from B to H1.
- w2, input, WW signed: H1 threshold (bias).
- w3, input, WW signed: weight from A to hidden neuron H2.
- w4, input, WW signed: weight from B to H2.
- w5, input, WW signed: H2 threshold.
- w6, input, WW signed: weight from H1 to the output neuron.
- w7, input, WW signed: weight from H2 to the output neuron.
- w8, input, WW signed: output-neuron threshold.
- y, output, 1: registered network output.
- tVal, output, WW signed: registered output-neuron pre-activation value (sum minus threshold).

Behaviour:
- Neuron rule: acc = sum over inputs (input_bit ? weight : 0) - bias. The sum is computed sign-extended to AW bits. The neuron fires (outputs 1) iff acc > 0, strictly; acc = 0 gives 0.
- Input bits are 0/1, so there are no multipliers: each weight is gated by its input bit.
- Stage 1, on each posedge clk:
  - h1 <= (A·w0 + B·w1 - w2) > 0
  - h2 <= (A·w3 + B·w4 - w5) > 0
  - x and w0..w5 are sampled at that edge.
- Stage 2, on each posedge clk:
  - acc_o = h1·w6 + h2·w7 - w8, using the registered h1/h2 and the w6..w8 values present at that edge.
  - y <= (acc_o > 0)
  - tVal <= acc_o reduced to WW bits (see Optional Feature).
- Latency: a change on x is reflected in y/tVal after the 2nd rising edge. A change on w6..w8 alone is reflected after 1 edge.
- Reset: rst_n low immediately clears h1, h2, y and tVal to 0, independent of clk. On release, the first edge loads stage 1 and the second edge produces a valid y.
- Reset mid-operation discards all in-flight data. No other state exists.
- Weights are not latched. Changing a weight between edges affects only the next edge.
- Extremes:
  - All weights -8 and bias +7 gives acc = -23, no overflow in AW.
  - Weights +7 and bias -8 gives acc = +22.
- No handshake: the pipeline advances every cycle.

Optional Feature:
- Macro: SIMPLE_NET_SAT_EN.
- Defined: tVal saturates acc_o to the WW-bit signed range, i.e. clamped to [-8, +7].
- Undefined: tVal is the low WW bits of acc_o (wrap-around).
- y is identical in both builds because it always uses the full AW-bit acc_o.

Test Plan:
- Reset: hold rst_n=0 with x=11 and clk toggling → y=0, tVal=0 throughout. Asynchronous clear verified by asserting rst_n between edges.
- XOR sweep, with w0..w8 = 2, 2, 1, 2, 2, 3, 2, -2, 1. Apply x=11, 10, 01, 00, each held at least 2 cycles:
  - x=11 → y=0, tVal=-1
  - x=10 → y=1, tVal=1
  - x=01 → y=1, tVal=1
  - x=00 → y=0, tVal=-1
- Latency: with the XOR weights, step x from 00 to 10 → y stays 0 after edge 1 and becomes 1 after edge 2.
- Threshold boundary: w6=2, w7=-2, w8=0, x=11 → acc_o=0 → y=0, tVal=0.
- Saturation: hidden weights as in the XOR sweep, x=11, w6=7, w7=7, w8=-8 → acc_o=22, y=1.
  - SIMPLE_NET_SAT_EN defined → tVal=7.
  - SIMPLE_NET_SAT_EN undefined → tVal=6.
- Reset mid-stream: during the XOR sweep, pulse rst_n low while x=10 and y=1 → y=0 immediately. After release, y returns to 1 on the 2nd edge.

Source files
------------

// File: rtl/simple_net_if.sv
// Signal bundle for the 2-2-1 perceptron: binary inputs, the nine live weights/biases,
// and the registered output bit plus the output neuron's pre-activation value.
interface simple_net_if #(
  parameter int WW = 4
);
  logic [1:0]           x;
  logic signed [WW-1:0] w0;
  logic signed [WW-1:0] w1;
  logic signed [WW-1:0] w2;
  logic signed [WW-1:0] w3;
  logic signed [WW-1:0] w4;
  logic signed [WW-1:0] w5;
  logic signed [WW-1:0] w6;
  logic signed [WW-1:0] w7;
  logic signed [WW-1:0] w8;
  logic                 y;
  logic signed [WW-1:0] tVal;

  modport master (
    output x, w0, w1, w2, w3, w4, w5, w6, w7, w8,
    input  y, tVal
  );

  modport slave (
    input  x, w0, w1, w2, w3, w4, w5, w6, w7, w8,
    output y, tVal
  );
endinterface

// File: rtl/simple_net.sv
// Two-stage pipelined 2-2-1 threshold-neuron network with live weights.
// SIMPLE_NET_SAT_EN: when defined, tVal saturates to the WW-bit range instead of wrapping.
module simple_net #(
  parameter int WW = 4,
  parameter int AW = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  simple_net_if.slave  bus
);

  localparam logic signed [AW-1:0] ZERO   = '0;
  localparam logic signed [AW-1:0] SAT_HI = AW'((2 ** (WW - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_LO = AW'(-(2 ** (WW - 1)));

  function automatic logic signed [AW-1:0] sx(input logic signed [WW-1:0] v);
    return {{(AW - WW){v[WW-1]}}, v};
  endfunction

  logic signed [WW-1:0] w_wa   [2];
  logic signed [WW-1:0] w_wb   [2];
  logic signed [WW-1:0] w_bias [2];
  logic [1:0]           w_hid;

  assign w_wa[0]   = bus.w0;
  assign w_wb[0]   = bus.w1;
  assign w_bias[0] = bus.w2;
  assign w_wa[1]   = bus.w3;
  assign w_wb[1]   = bus.w4;
  assign w_bias[1] = bus.w5;

  // Input bits are 0/1, so each weight is simply gated by its bit.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hidden
      logic signed [AW-1:0] w_acc;
      assign w_acc = (bus.x[0] ? sx(w_wa[gi]) : ZERO)
                   + (bus.x[1] ? sx(w_wb[gi]) : ZERO)
                   - sx(w_bias[gi]);
      assign w_hid[gi] = (w_acc > ZERO);
    end
  endgenerate

  logic [1:0]           r_h;
  logic                 r_y;
  logic signed [WW-1:0] r_tval;
  logic signed [AW-1:0] w_acc_o;
  logic signed [WW-1:0] w_tval_next;

  assign w_acc_o = (r_h[0] ? sx(bus.w6) : ZERO)
                 + (r_h[1] ? sx(bus.w7) : ZERO)
                 - sx(bus.w8);

  always_comb begin
    w_tval_next = w_acc_o[WW-1:0];
`ifdef SIMPLE_NET_SAT_EN
    if (w_acc_o > SAT_HI) begin
      w_tval_next = SAT_HI[WW-1:0];
    end else if (w_acc_o < SAT_LO) begin
      w_tval_next = SAT_LO[WW-1:0];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h    <= 2'b00;
      r_y    <= 1'b0;
      r_tval <= '0;
    end else begin
      r_h    <= w_hid;
      r_y    <= (w_acc_o > ZERO);
      r_tval <= w_tval_next;
    end
  end

  assign bus.y    = r_y;
  assign bus.tVal = r_tval;

endmodule

// File: tb/tb_simple_net.sv
// Scoreboard bench for simple_net: stimulus pushes expected {y,tVal} per edge from an
// integer reference model; a monitor pops and compares after every rising edge.
module tb_simple_net;

  typedef struct {
    bit y;
    int t;
  } exp_t;

  logic clk;
  logic rst_n;
  simple_net_if #(.WW(4)) bus();

  simple_net #(.WW(4), .AW(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_h1 = 0;
  int   m_h2 = 0;
  bit   last_y = 1'b0;
  int   cur_w[9];
  int   n_step = 0;

  function automatic int fire(input int acc);
    return (acc > 0) ? 1 : 0;
  endfunction

  function automatic int reduce(input int acc);
    int t;
`ifdef SIMPLE_NET_SAT_EN
    t = (acc > 7) ? 7 : ((acc < -8) ? -8 : acc);
`else
    t = acc & 15;
    if (t > 7) t = t - 16;
`endif
    return t;
  endfunction

  // Monitor: compares whatever the stimulus predicted for this edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        int   act_t;
        e     = exp_q.pop_front();
        act_t = int'($signed(bus.tVal));
        n_checks++;
        if (bus.y !== e.y || act_t != e.t) begin
          n_fail++;
          $display("FAIL pipe_out t=%0t: y=%0b tVal=%0d, required y=%0b tVal=%0d",
                   $time, bus.y, act_t, e.y, e.t);
        end else begin
          $display("ok   pipe_out t=%0t: x=%b y=%0b tVal=%0d", $time, bus.x, bus.y, act_t);
        end
      end
    end
  end

  // Drive one cycle of stimulus at the falling edge and predict the next rising edge.
  task automatic step(input logic [1:0] xv, input bit rst_val);
    int   a, b, acc_o;
    exp_t e;
    @(negedge clk);
    rst_n   = rst_val;
    bus.x   = xv;
    bus.w0  = 4'(cur_w[0]);
    bus.w1  = 4'(cur_w[1]);
    bus.w2  = 4'(cur_w[2]);
    bus.w3  = 4'(cur_w[3]);
    bus.w4  = 4'(cur_w[4]);
    bus.w5  = 4'(cur_w[5]);
    bus.w6  = 4'(cur_w[6]);
    bus.w7  = 4'(cur_w[7]);
    bus.w8  = 4'(cur_w[8]);
    a = int'(xv[0]);
    b = int'(xv[1]);
    if (!rst_val) begin
      m_h1 = 0;
      m_h2 = 0;
      e.y  = 1'b0;
      e.t  = 0;
    end else begin
      acc_o = m_h1 * cur_w[6] + m_h2 * cur_w[7] - cur_w[8];
      e.y   = bit'(fire(acc_o));
      e.t   = reduce(acc_o);
      m_h1  = fire(a * cur_w[0] + b * cur_w[1] - cur_w[2]);
      m_h2  = fire(a * cur_w[3] + b * cur_w[4] - cur_w[5]);
    end
    last_y = e.y;
    exp_q.push_back(e);
    n_step++;
  endtask

  task automatic set_w(input int a0, input int a1, input int a2, input int a3, input int a4,
                       input int a5, input int a6, input int a7, input int a8);
    cur_w[0] = a0; cur_w[1] = a1; cur_w[2] = a2;
    cur_w[3] = a3; cur_w[4] = a4; cur_w[5] = a5;
    cur_w[6] = a6; cur_w[7] = a7; cur_w[8] = a8;
  endtask

  // Asynchronous clear between edges, checked right away.
  task automatic async_reset_check();
    int act_t;
    bit was_y;
    @(posedge clk);
    #3;
    was_y = last_y;
    n_checks++;
    if (bus.y !== was_y) begin
      n_fail++;
      $display("FAIL pre_reset_y t=%0t: y=%0b, required %0b", $time, bus.y, was_y);
    end
    rst_n = 1'b0;
    #1;
    act_t = int'($signed(bus.tVal));
    n_checks++;
    if (bus.y !== 1'b0 || act_t != 0) begin
      n_fail++;
      $display("FAIL async_clear t=%0t: y=%0b tVal=%0d, required y=0 tVal=0", $time, bus.y, act_t);
    end else begin
      $display("ok   async_clear t=%0t: y=0 tVal=0", $time);
    end
    m_h1 = 0;
    m_h2 = 0;
  endtask

  logic [1:0] xs [4];

  initial begin
    rst_n = 1'b0;
    set_w(2, 2, 1, 2, 2, 3, 2, -2, 1);
    bus.x = 2'b11;
    bus.w0 = '0; bus.w1 = '0; bus.w2 = '0; bus.w3 = '0; bus.w4 = '0;
    bus.w5 = '0; bus.w6 = '0; bus.w7 = '0; bus.w8 = '0;

    // Reset held with clock running and x=11.
    repeat (3) step(2'b11, 1'b0);

    // XOR sweep, each pattern held 3 cycles.
    xs[0] = 2'b11; xs[1] = 2'b10; xs[2] = 2'b01; xs[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      repeat (3) step(xs[i], 1'b1);
    end

    // Latency: 00 -> 10, y rises only after the second edge.
    repeat (2) step(2'b00, 1'b1);
    repeat (3) step(2'b10, 1'b1);

    // Mid-stream reset while y=1, then recovery.
    async_reset_check();
    step(2'b10, 1'b0);
    repeat (3) step(2'b10, 1'b1);

    // Output threshold boundary: acc_o = 0.
    set_w(2, 2, 1, 2, 2, 3, 2, -2, 0);
    repeat (3) step(2'b11, 1'b1);

    // Saturation / wrap of tVal at acc_o = +22.
    set_w(2, 2, 1, 2, 2, 3, 7, 7, -8);
    repeat (3) step(2'b11, 1'b1);

    // Extreme negative hidden accumulators, and most negative output accumulator.
    set_w(-8, -8, 7, -8, -8, 7, -8, -8, 7);
    repeat (3) step(2'b11, 1'b1);
    set_w(7, 7, -8, 7, 7, -8, -8, -8, 7);
    repeat (3) step(2'b11, 1'b1);

    // Random weights and inputs, changing every cycle.
    for (int i = 0; i < 200; i++) begin
      for (int k = 0; k < 9; k++) begin
        cur_w[k] = int'($urandom_range(15)) - 8;
      end
      step(2'($urandom_range(3)), ($urandom_range(31) != 0));
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
